// File: rtl/extended_axis_packet_merger_if.sv
// Multi-channel AXI-Stream bundle; every field is a flat CHANNELS x width vector.
// master drives payload/valid/last, slave drives ready.
interface extended_axis_packet_merger_if #(
    parameter int CHANNELS   = 1,
    parameter int DATA_WIDTH = 16,
    parameter int KEEP_WIDTH = 2,
    parameter int ID_WIDTH   = 1,
    parameter int DEST_WIDTH = 1,
    parameter int USER_WIDTH = 1
);
    logic [CHANNELS*DATA_WIDTH-1:0] tdata;
    logic [CHANNELS*KEEP_WIDTH-1:0] tkeep;
    logic [CHANNELS-1:0]            tvalid;
    logic [CHANNELS-1:0]            tready;
    logic [CHANNELS-1:0]            tlast;
    logic [CHANNELS*ID_WIDTH-1:0]   tid;
    logic [CHANNELS*DEST_WIDTH-1:0] tdest;
    logic [CHANNELS*USER_WIDTH-1:0] tuser;

    modport master (output tdata, tkeep, tvalid, tlast, tid, tdest, tuser, input tready);
    modport slave  (input tdata, tkeep, tvalid, tlast, tid, tdest, tuser, output tready);
endinterface

// File: rtl/extended_axis_packet_merger.sv
// Concatenates packet_count fixed-size packets per channel into one frame, regenerating tlast.
// Optional tlast length checking: define EXTENDED_AXIS_PACKET_MERGER_LENGTH_CHECK_EN.
module extended_axis_packet_merger #(
    parameter int CHANNELS    = 1,
    parameter int DATA_WIDTH  = 16,
    parameter int KEEP_ENABLE = (DATA_WIDTH > 8) ? 1 : 0,
    parameter int KEEP_WIDTH  = (KEEP_ENABLE != 0) ? (DATA_WIDTH + 7) / 8 : 1,
    parameter int ID_ENABLE   = 0,
    parameter int ID_WIDTH    = (ID_ENABLE != 0) ? 8 : 1,
    parameter int DEST_ENABLE = 0,
    parameter int DEST_WIDTH  = (DEST_ENABLE != 0) ? 8 : 1,
    parameter int USER_ENABLE = 0,
    parameter int USER_WIDTH  = (USER_ENABLE != 0) ? 8 : 1,
    parameter int PCKT_WIDTH  = 32,
    parameter int CNT_WIDTH   = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  operation_start,
    input  logic [PCKT_WIDTH-1:0] packet_size,
    input  logic [CNT_WIDTH-1:0]  packet_count,
    input  logic                  external_error,
    output logic                  operation_busy,
    output logic                  operation_complete,
    output logic                  operation_error,
    output logic [1:0]            state_dbg,
    extended_axis_packet_merger_if.slave  s_axis,
    extended_axis_packet_merger_if.master m_axis
);
    // Handshake: a beat moves on channel ch when tvalid[ch] & tready[ch] are both high at
    // posedge clk; valid never waits on ready, and both are gated off outside an active frame.

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DONE  = 2'd2,
        ST_ERROR = 2'd3
    } state_t;

    state_t state, state_next;

    logic [PCKT_WIDTH-1:0] size_q;
    logic [CNT_WIDTH-1:0]  count_q;
    logic [PCKT_WIDTH-1:0] beat_cnt [CHANNELS];
    logic [CNT_WIDTH-1:0]  pkt_cnt  [CHANNELS];
    logic [CHANNELS-1:0]   done;

    logic                  params_bad;
    logic                  start_take;
    logic [CHANNELS-1:0]   chan_active;
    logic [CHANNELS-1:0]   hs;
    logic [CHANNELS-1:0]   last_beat;
    logic [CHANNELS-1:0]   final_beat;
    logic [CHANNELS-1:0]   tlast_force;
    logic [CHANNELS-1:0]   len_err;

    assign params_bad = (packet_size == '0) || (packet_count == '0);
    assign start_take = operation_start && (state != ST_RUN) && !params_bad;
    assign state_dbg  = state;

    // Per-channel frame position decode and handshake detection.
    always_comb begin : chan_decode
        chan_active = '0;
        hs          = '0;
        last_beat   = '0;
        final_beat  = '0;
        tlast_force = '0;
        len_err     = '0;
        for (int ch = 0; ch < CHANNELS; ch++) begin
            chan_active[ch] = (state == ST_RUN) && !done[ch];
            hs[ch]          = s_axis.tvalid[ch] && m_axis.tready[ch] && chan_active[ch];
            last_beat[ch]   = (beat_cnt[ch] == size_q - PCKT_WIDTH'(1));
            final_beat[ch]  = last_beat[ch] && (pkt_cnt[ch] == count_q - CNT_WIDTH'(1));
`ifdef EXTENDED_AXIS_PACKET_MERGER_LENGTH_CHECK_EN
            // A misplaced input tlast closes the output frame early and aborts the run.
            tlast_force[ch] = (s_axis.tlast[ch] != last_beat[ch]);
            len_err[ch]     = hs[ch] && tlast_force[ch];
`endif
        end
    end

`ifndef EXTENDED_AXIS_PACKET_MERGER_LENGTH_CHECK_EN
    logic tlast_unused;
    assign tlast_unused = ^s_axis.tlast;
`endif

    always_ff @(posedge clk) begin : state_reg
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin : next_state_logic
        state_next = state;
        case (state)
            ST_IDLE, ST_DONE, ST_ERROR: begin
                if (operation_start) begin
                    state_next = params_bad ? ST_ERROR : ST_RUN;
                end
            end
            ST_RUN: begin
                // Abort outranks completion; the final beat still transfers this cycle.
                if (external_error || (|len_err)) begin
                    state_next = ST_ERROR;
                end else if (&(done | (hs & final_beat))) begin
                    state_next = ST_DONE;
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    always_comb begin : output_logic
        operation_busy     = (state == ST_RUN);
        operation_complete = (state == ST_DONE);
        operation_error    = (state == ST_ERROR);
        s_axis.tready      = '0;
        m_axis.tvalid      = '0;
        m_axis.tlast       = '0;
        for (int ch = 0; ch < CHANNELS; ch++) begin
            s_axis.tready[ch] = m_axis.tready[ch] && chan_active[ch];
            m_axis.tvalid[ch] = s_axis.tvalid[ch] && chan_active[ch];
            m_axis.tlast[ch]  = chan_active[ch] && (final_beat[ch] || tlast_force[ch]);
        end
        m_axis.tdata = s_axis.tdata;
        m_axis.tkeep = (KEEP_ENABLE != 0) ? s_axis.tkeep : '1;
        m_axis.tid   = (ID_ENABLE   != 0) ? s_axis.tid   : '0;
        m_axis.tdest = (DEST_ENABLE != 0) ? s_axis.tdest : '0;
        m_axis.tuser = (USER_ENABLE != 0) ? s_axis.tuser : '0;
    end

    always_ff @(posedge clk) begin : counters
        if (rst) begin
            size_q  <= '0;
            count_q <= '0;
            done    <= '0;
            for (int ch = 0; ch < CHANNELS; ch++) begin
                beat_cnt[ch] <= '0;
                pkt_cnt[ch]  <= '0;
            end
        end else if (start_take) begin
            size_q  <= packet_size;
            count_q <= packet_count;
            done    <= '0;
            for (int ch = 0; ch < CHANNELS; ch++) begin
                beat_cnt[ch] <= '0;
                pkt_cnt[ch]  <= '0;
            end
        end else begin
            for (int ch = 0; ch < CHANNELS; ch++) begin
                if (hs[ch]) begin
                    if (last_beat[ch]) begin
                        beat_cnt[ch] <= '0;
                        if (final_beat[ch]) begin
                            done[ch] <= 1'b1;
                        end else begin
                            pkt_cnt[ch] <= pkt_cnt[ch] + CNT_WIDTH'(1);
                        end
                    end else begin
                        beat_cnt[ch] <= beat_cnt[ch] + PCKT_WIDTH'(1);
                    end
                end
            end
        end
    end
endmodule

// File: tb/tb_extended_axis_packet_merger.sv
// Randomized bench for extended_axis_packet_merger: two channels, frame-level reference model.
module tb_extended_axis_packet_merger;
    localparam int CH = 2;
    localparam int DW = 16;
    localparam int KW = 2;
    localparam int PW = 32;
    localparam int CW = 16;
    localparam int BUDGET = 600;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic          operation_start = 1'b0;
    logic [PW-1:0] packet_size = '0;
    logic [CW-1:0] packet_count = '0;
    logic          external_error = 1'b0;
    logic          operation_busy, operation_complete, operation_error;
    logic [1:0]    state_dbg;

    extended_axis_packet_merger_if #(.CHANNELS(CH), .DATA_WIDTH(DW), .KEEP_WIDTH(KW),
        .ID_WIDTH(1), .DEST_WIDTH(1), .USER_WIDTH(1)) s_if();
    extended_axis_packet_merger_if #(.CHANNELS(CH), .DATA_WIDTH(DW), .KEEP_WIDTH(KW),
        .ID_WIDTH(1), .DEST_WIDTH(1), .USER_WIDTH(1)) m_if();

    extended_axis_packet_merger #(.CHANNELS(CH), .DATA_WIDTH(DW), .PCKT_WIDTH(PW), .CNT_WIDTH(CW)) dut (
        .clk                (clk),
        .rst                (rst),
        .operation_start    (operation_start),
        .packet_size        (packet_size),
        .packet_count       (packet_count),
        .external_error     (external_error),
        .operation_busy     (operation_busy),
        .operation_complete (operation_complete),
        .operation_error    (operation_error),
        .state_dbg          (state_dbg),
        .s_axis             (s_if.slave),
        .m_axis             (m_if.master)
    );

    // ---------------- scoreboard ----------------
    int n_checks = 0;
    int n_pass   = 0;
    logic [KW+DW-1:0] exp_q[$];

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    endtask

    // ---------------- driver tasks ----------------
    task automatic idle_inputs(input logic v, input logic r);
        s_if.tvalid = {CH{v}};
        m_if.tready = {CH{r}};
        s_if.tlast  = '0;
        s_if.tdata  = '0;
        s_if.tkeep  = '0;
        s_if.tid    = '0;
        s_if.tdest  = '0;
        s_if.tuser  = '0;
    endtask

    task automatic start_op(input int size, input int count);
        @(negedge clk);
        external_error  = 1'b0;
        idle_inputs(1'b0, 1'b0);
        packet_size     = PW'(size);
        packet_count    = CW'(count);
        operation_start = 1'b1;
        @(negedge clk);
        operation_start = 1'b0;
    endtask

    // Checks status one cycle after a frame ends; handshakes must be gated off.
    task automatic check_end(input string tag, input bit exp_err);
        @(negedge clk);
        external_error = 1'b0;
        idle_inputs(1'b1, 1'b1);
        #1;
        check({tag, "_busy"},     64'(operation_busy),     64'(0));
        check({tag, "_complete"}, 64'(operation_complete), 64'(!exp_err));
        check({tag, "_error"},    64'(operation_error),    64'(exp_err));
        check({tag, "_m_tvalid"}, 64'(m_if.tvalid),        64'(0));
        check({tag, "_s_tready"}, 64'(s_if.tready),        64'(0));
    endtask

    // Drives one frame with random valid/ready; model: each channel owes size*count beats,
    // output tlast only on the last of them. result: 0 done, 1 error, 2 aborted, 3 timeout.
    task automatic run_frame(input int size, input int count, input int stall1, input int abort_at,
                             input bit ext_final, input int bad_at, output int result);
        int total;
        int n[CH];
        int cyc;
        bit act[CH];
        bit hs[CH];
        bit stop, exp_tl, len_bad, all_fin, any_last, all_done;
        logic [DW-1:0] d;
        logic [KW-1:0] k;
        total  = size * count;
        cyc    = 0;
        stop   = 0;
        result = 3;
        for (int ch = 0; ch < CH; ch++) n[ch] = 0;
        while (!stop) begin
            @(negedge clk);
            external_error = 1'b0;
            for (int ch = 0; ch < CH; ch++) begin
                s_if.tvalid[ch] = ($urandom_range(0, 3) != 0);
                m_if.tready[ch] = (ch == 1 && cyc < stall1) ? 1'b0 : ($urandom_range(0, 3) != 0);
                s_if.tdata[ch*DW +: DW] = DW'($urandom);
                s_if.tkeep[ch*KW +: KW] = KW'($urandom);
`ifdef EXTENDED_AXIS_PACKET_MERGER_LENGTH_CHECK_EN
                s_if.tlast[ch] = ((n[ch] % size) == size - 1);
                if (ch == 0 && n[0] == bad_at) s_if.tlast[0] = ~s_if.tlast[0];
`else
                s_if.tlast[ch] = 1'($urandom_range(0, 1));
`endif
                act[ch] = (n[ch] < total);
                hs[ch]  = act[ch] && s_if.tvalid[ch] && m_if.tready[ch];
            end
            if (ext_final) begin
                all_fin  = 1;
                any_last = 0;
                for (int ch = 0; ch < CH; ch++) begin
                    if (n[ch] + int'(hs[ch]) != total) all_fin = 0;
                    if (hs[ch] && n[ch] == total - 1) any_last = 1;
                end
                if (all_fin && any_last) external_error = 1'b1;
            end
            #1;
            check("busy_in_run", 64'(operation_busy), 64'(1));
            len_bad = 0;
            for (int ch = 0; ch < CH; ch++) begin
                check("m_tvalid", 64'(m_if.tvalid[ch]), 64'(s_if.tvalid[ch] && act[ch]));
                check("s_tready", 64'(s_if.tready[ch]), 64'(m_if.tready[ch] && act[ch]));
                if (hs[ch]) begin
                    d = s_if.tdata[ch*DW +: DW];
                    k = s_if.tkeep[ch*KW +: KW];
                    exp_q.push_back({k, d});
                    check("beat", 64'({m_if.tkeep[ch*KW +: KW], m_if.tdata[ch*DW +: DW]}), 64'(exp_q.pop_front()));
                    exp_tl = (n[ch] == total - 1);
`ifdef EXTENDED_AXIS_PACKET_MERGER_LENGTH_CHECK_EN
                    if (s_if.tlast[ch] != ((n[ch] % size) == size - 1)) begin
                        exp_tl  = 1;
                        len_bad = 1;
                    end
`endif
                    check("m_tlast", 64'(m_if.tlast[ch]), 64'(exp_tl));
                    n[ch]++;
                end
            end
            cyc++;
            all_done = 1;
            for (int ch = 0; ch < CH; ch++) if (n[ch] != total) all_done = 0;
            if (external_error || len_bad) begin
                result = 1; stop = 1;
            end else if (all_done) begin
                result = 0; stop = 1;
            end else if (abort_at >= 0 && n[0] >= abort_at) begin
                result = 2; stop = 1;
            end else if (cyc >= BUDGET) begin
                check("frame_timeout", 64'(1), 64'(0));
                stop = 1;
            end
        end
    endtask

    // ---------------- test sequence ----------------
    int res;
    int rs, rc;

    initial begin
        idle_inputs(1'b1, 1'b1);
        repeat (3) @(negedge clk);
        #1;
        check("rst_busy",     64'(operation_busy),     64'(0));
        check("rst_complete", 64'(operation_complete), 64'(0));
        check("rst_error",    64'(operation_error),    64'(0));
        check("rst_m_tvalid", 64'(m_if.tvalid),        64'(0));
        check("rst_s_tready", 64'(s_if.tready),        64'(0));
        check("rst_state",    64'(state_dbg),          64'(0));
        rst = 1'b0;

        // 4-beat packets, 3 per frame
        start_op(4, 3);
        check("a_busy", 64'(operation_busy), 64'(1));
        run_frame(4, 3, 0, -1, 0, -1, res);
        check("a_result", 64'(res), 64'(0));
        check_end("a", 0);

        // channel 1 stalled; completion waits for it
        start_op(2, 2);
        run_frame(2, 2, 10, -1, 0, -1, res);
        check("b_result", 64'(res), 64'(0));
        check_end("b", 0);

        // external error on the very last beat
        start_op(3, 2);
        run_frame(3, 2, 0, -1, 1, -1, res);
        check("c_result", 64'(res), 64'(1));
        check_end("c", 1);
        start_op(2, 1);
        #1;
        check("c_restart_busy",  64'(operation_busy),  64'(1));
        check("c_restart_error", 64'(operation_error), 64'(0));
        run_frame(2, 1, 0, -1, 0, -1, res);
        check_end("c2", 0);

        // zero packet_count, then zero packet_size
        start_op(4, 0);
        m_if.tready = '1;
        s_if.tvalid = '1;
        #1;
        check("zc_error",    64'(operation_error), 64'(1));
        check("zc_busy",     64'(operation_busy),  64'(0));
        check("zc_s_tready", 64'(s_if.tready),     64'(0));
        start_op(0, 3);
        m_if.tready = '1;
        #1;
        check("zs_error",    64'(operation_error), 64'(1));
        check("zs_s_tready", 64'(s_if.tready),     64'(0));

        // reset mid-frame, then a full frame with the same sizes
        start_op(4, 3);
        run_frame(4, 3, 0, 5, 0, -1, res);
        check("r_aborted", 64'(res), 64'(2));
        @(negedge clk);
        rst = 1'b1;
        idle_inputs(1'b1, 1'b1);
        @(negedge clk);
        #1;
        check("r_busy",     64'(operation_busy), 64'(0));
        check("r_m_tvalid", 64'(m_if.tvalid),    64'(0));
        check("r_s_tready", 64'(s_if.tready),    64'(0));
        rst = 1'b0;
        start_op(4, 3);
        run_frame(4, 3, 0, -1, 0, -1, res);
        check("r_result", 64'(res), 64'(0));
        check_end("r", 0);

        // single-beat packets, single-packet frame
        start_op(1, 1);
        run_frame(1, 1, 0, -1, 0, -1, res);
        check_end("one", 0);

`ifdef EXTENDED_AXIS_PACKET_MERGER_LENGTH_CHECK_EN
        // early tlast on the third beat of channel 0
        start_op(4, 3);
        run_frame(4, 3, 0, -1, 0, 2, res);
        check("len_result", 64'(res), 64'(1));
        check_end("len", 1);
`endif

        for (int i = 0; i < 6; i++) begin
            rs = int'($urandom_range(1, 5));
            rc = int'($urandom_range(1, 4));
            start_op(rs, rc);
            run_frame(rs, rc, int'($urandom_range(0, 6)), -1, 0, -1, res);
            check("rand_result", 64'(res), 64'(0));
            check_end("rand", 0);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
